uart_tx_report: RTL and testbench

- UART 8N1 transmitter that returns a status/readback frame to the host PC, the opposite direction of the existing UART receive path.
- Triggered by end-of-sequence (END_FLG domain) or a host request.
- Reads LEN bytes from the config RAM readback port and transmits them with a header, a type byte and an XOR checksum.
- Runs on the board clock `clk`, alongside the UART receiver and RAM.

---
 rtl/uart_tx_report_pkg.sv | 32 +++
 rtl/uart_tx_report_if.sv | 13 +
 rtl/uart_tx_report_byte.sv | 93 +++++++++
 rtl/uart_tx_report.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_report.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_report_pkg.sv
// Shared constants and state encodings for the UART status/readback transmitter.
package uart_tx_report_pkg;

    localparam logic [7:0] HEADER_BYTE  = 8'hA5;
    localparam int         TYPE_END_BIT = 0;
    localparam int         TYPE_REQ_BIT = 1;

    typedef enum logic [2:0] {
        F_IDLE = 3'd0,
        F_HDR  = 3'd1,
        F_TYP  = 3'd2,
        F_DAT  = 3'd3,
        F_CSM  = 3'd4,
        F_FIN  = 3'd5
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_BITS  = 2'd2,
        B_STOP  = 2'd3
    } byte_state_t;

    function automatic logic [7:0] make_type(input logic end_bit, input logic req_bit);
        logic [7:0] t;
        t               = 8'h00;
        t[TYPE_END_BIT] = end_bit;
        t[TYPE_REQ_BIT] = req_bit;
        return t;
    endfunction

endpackage

// File: rtl/uart_tx_report_if.sv
// Trigger, RAM readback and serial/status signals of the report transmitter.
interface uart_tx_report_if;
    logic       end_flg;
    logic       req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output end_flg, req, rd_data, input rd_addr, tx, busy, done);
    modport slave  (input end_flg, req, rd_data, output rd_addr, tx, busy, done);
endinterface

// File: rtl/uart_tx_report_byte.sv
// 8N1 byte serializer; ready rises in the last stop-bit cycle so bytes can run back-to-back.
module uart_tx_byte
    import uart_tx_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       stop_next,
    output logic       tx
);
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    byte_state_t   state_r;
    byte_state_t   state_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          bit_end_s;
    logic          load_s;

    assign bit_end_s = (cnt_r == CNT_LAST);
    assign ready     = (state_r == B_IDLE) || ((state_r == B_STOP) && bit_end_s);
    assign load_s    = valid && ready;
    // stop_next marks the final cycle of bit 7, i.e. the stop bit begins at the next edge
    assign stop_next = (state_r == B_BITS) && (bit_r == 3'd7) && bit_end_s;
    assign tx        = tx_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= B_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        if (load_s) begin
            state_s = B_START;
        end else begin
            case (state_r)
                B_START: state_s = bit_end_s ? B_BITS : B_START;
                B_BITS:  state_s = stop_next ? B_STOP : B_BITS;
                B_STOP:  state_s = bit_end_s ? B_IDLE : B_STOP;
                default: state_s = B_IDLE;
            endcase
        end
    end

    // Bit timing, shift register and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else if (load_s) begin
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= data;
            tx_r    <= 1'b0;
        end else if (state_r == B_IDLE) begin
            cnt_r <= {CW{1'b0}};
            tx_r  <= 1'b1;
        end else if (bit_end_s) begin
            cnt_r <= {CW{1'b0}};
            case (state_r)
                B_START: tx_r <= shift_r[0];
                B_BITS: begin
                    if (bit_r == 3'd7) begin
                        tx_r <= 1'b1;
                    end else begin
                        bit_r   <= bit_r + 3'd1;
                        shift_r <= shift_r >> 1;
                        tx_r    <= shift_r[1];
                    end
                end
                default: tx_r <= 1'b1;
            endcase
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_report.sv
// Frame sequencer: HEADER, TYPE, LEN RAM bytes and XOR checksum, with one-deep trigger pending.
module uart_tx_report
    import uart_tx_report_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 5208,
    parameter int         LEN          = 16,
    parameter logic [7:0] HEADER       = HEADER_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_report_if.slave        bus
);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    frame_state_t state_r;
    frame_state_t state_s;
    logic         valid_s, ready_s, stop_next_s, tx_s, fetch_s;
    logic [7:0]   byte_s;
    logic         start_s, load_typ_s, load_dat_s, chain_s;
    logic         trig_r, pend_r, chain_r, cap1_r, cap2_r, busy_r, done_r;
    logic [7:0]   trig_type_r, pend_type_r, type_r, csum_r, idx_r, data_r, rd_addr_r;

    assign bus.rd_addr = rd_addr_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.tx      = tx_s;
    // Prefetch the next data byte as the current byte enters its stop bit
    assign fetch_s = stop_next_s &&
                     ((state_r == F_TYP) || ((state_r == F_DAT) && (idx_r != LAST_IDX)));

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk       (clk),
        .rst       (rst),
        .data      (byte_s),
        .valid     (valid_s),
        .ready     (ready_s),
        .stop_next (stop_next_s),
        .tx        (tx_s)
    );

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= F_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame next-state and byte hand-off
    always_comb begin
        state_s    = state_r;
        valid_s    = 1'b0;
        byte_s     = 8'h00;
        start_s    = 1'b0;
        load_typ_s = 1'b0;
        load_dat_s = 1'b0;
        chain_s    = 1'b0;
        case (state_r)
            F_IDLE: begin
                if (trig_r) begin
                    valid_s = 1'b1; byte_s = HEADER; start_s = 1'b1; state_s = F_HDR;
                end else begin
                    state_s = F_IDLE;
                end
            end
            F_HDR: begin
                if (ready_s) begin
                    valid_s = 1'b1; byte_s = type_r; load_typ_s = 1'b1; state_s = F_TYP;
                end else begin
                    state_s = F_HDR;
                end
            end
            F_TYP: begin
                if (ready_s) begin
                    valid_s = 1'b1; byte_s = data_r; load_dat_s = 1'b1; state_s = F_DAT;
                end else begin
                    state_s = F_TYP;
                end
            end
            F_DAT: begin
                if (ready_s && (idx_r == LAST_IDX)) begin
                    valid_s = 1'b1; byte_s = csum_r; state_s = F_CSM;
                end else if (ready_s) begin
                    valid_s = 1'b1; byte_s = data_r; load_dat_s = 1'b1; state_s = F_DAT;
                end else begin
                    state_s = F_DAT;
                end
            end
            F_CSM: begin
                // A pending trigger chains the next HEADER straight after this stop bit
                if (ready_s && (pend_r || trig_r)) begin
                    valid_s = 1'b1; byte_s = HEADER; start_s = 1'b1; chain_s = 1'b1; state_s = F_FIN;
                end else if (ready_s) begin
                    state_s = F_FIN;
                end else begin
                    state_s = F_CSM;
                end
            end
            F_FIN: begin
                if (chain_r) begin
                    state_s = F_HDR;
                end else if (trig_r) begin
                    valid_s = 1'b1; byte_s = HEADER; start_s = 1'b1; state_s = F_HDR;
                end else begin
                    state_s = F_IDLE;
                end
            end
            default: state_s = F_IDLE;
        endcase
    end

    // Trigger capture, pending merge, checksum, index, RAM prefetch and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_r      <= 1'b0;
            trig_type_r <= 8'h00;
            pend_r      <= 1'b0;
            pend_type_r <= 8'h00;
            type_r      <= 8'h00;
            csum_r      <= 8'h00;
            idx_r       <= 8'h00;
            data_r      <= 8'h00;
            rd_addr_r   <= 8'h00;
            cap1_r      <= 1'b0;
            cap2_r      <= 1'b0;
            chain_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            trig_r      <= bus.end_flg | bus.req;
            trig_type_r <= make_type(bus.end_flg, bus.req);
            if (start_s) begin
                type_r      <= pend_type_r | trig_type_r;
                pend_r      <= 1'b0;
                pend_type_r <= 8'h00;
            end else if (trig_r) begin
                pend_r      <= 1'b1;
                pend_type_r <= pend_type_r | trig_type_r;
            end
            if (start_s) begin
                csum_r <= 8'h00;
                idx_r  <= 8'hFF;
            end else if (load_typ_s) begin
                csum_r <= type_r;
            end else if (load_dat_s) begin
                csum_r <= csum_r ^ data_r;
                idx_r  <= idx_r + 8'd1;
            end
            if ((state_r == F_IDLE) || (state_r == F_FIN)) begin
                rd_addr_r <= 8'h00;
            end else if (fetch_s) begin
                rd_addr_r <= idx_r + 8'd1;
            end
            cap1_r <= fetch_s;
            cap2_r <= cap1_r;
            if (cap2_r) begin
                data_r <= bus.rd_data;
            end
            chain_r <= chain_s;
            busy_r  <= (state_s == F_HDR) || (state_s == F_TYP) ||
                       (state_s == F_DAT) || (state_s == F_CSM);
            done_r  <= (state_s == F_FIN);
        end
    end

endmodule

// File: tb/tb_uart_tx_report.sv
// Self-checking bench: per-cycle line model of each frame plus decoded-byte checks.
module tb_uart_tx_report;
    localparam int CPB       = 4;
    localparam int LEN       = 2;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = (LEN + 3) * BYTE_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ram [LEN];
    logic [7:0] dec_q [$];
    bit         garbage = 1'b0;
    int         checks = 0;
    int         failures = 0;

    uart_tx_report_if bus ();

    uart_tx_report #(.CLKS_PER_BIT(CPB), .LEN(LEN), .HEADER(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_word(input logic [7:0] a);
        return (int'(a) < LEN) ? ram[a] : 8'hEE;
    endfunction

    // Synchronous-read RAM: data for an address appears the cycle after it is presented.
    // In garbage mode it is only valid the cycle right after an address change (or at 0).
    initial begin
        logic [7:0] cur, last_a, val;
        last_a = 8'h00;
        bus.rd_data = 8'h00;
        forever begin
            @(posedge clk);
            cur = bus.rd_addr;
            if (!garbage || cur != last_a || cur == 8'h00) val = ram_word(cur);
            else val = ram_word(cur) ^ 8'($urandom_range(1, 255));
            last_a = cur;
            #1 bus.rd_data = val;
        end
    end

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] typ);
        logic [7:0] cs;
        if (i == 0) return 8'hA5;
        if (i == 1) return typ;
        if (i < LEN + 2) return ram[i - 2];
        cs = typ;
        for (int j = 0; j < LEN; j++) cs = cs ^ ram[j];
        return cs;
    endfunction

    function automatic logic exp_tx(input int c, input logic [7:0] typ);
        int pos;
        logic [7:0] v;
        v   = exp_byte(c / BYTE_CYC, typ);
        pos = (c % BYTE_CYC) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return v[pos - 1];
    endfunction

    // Pulse triggers, confirm nothing moves in the sampling cycle, step to the first frame cycle
    task automatic start(input logic e, input logic r, input string tag);
        bus.end_flg = e;
        bus.req     = r;
        @(posedge clk); #1;
        bus.end_flg = 1'b0;
        bus.req     = 1'b0;
        checks++;
        if ({bus.busy, bus.tx} !== 2'b01) begin
            failures++;
            $display("FAIL %s latency busy,tx got %b want 01", tag, {bus.busy, bus.tx});
        end
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input logic [7:0] typ, input bit from_fin, input int n_inj, input string tag);
        logic [BYTE_CYC-1:0] obs, expv;
        logic [7:0] dec;
        int bad_ctl, pos;
        int inj [3];
        bad_ctl = 0;
        dec = 8'h00;
        dec_q.delete();
        for (int i = 0; i < 3; i++) inj[i] = $urandom_range(10 + 60 * i, 60 + 60 * i);
        for (int c = 0; c < FRAME_CYC; c++) begin
            obs[c % BYTE_CYC]  = bus.tx;
            expv[c % BYTE_CYC] = exp_tx(c, typ);
            pos = (c % BYTE_CYC) / CPB;
            if ((c % CPB) == CPB / 2 && pos >= 1 && pos <= 8) dec[pos - 1] = bus.tx;
            if (bus.busy !== !(from_fin && c == 0)) bad_ctl++;
            if (bus.done !== (from_fin && c == 0)) bad_ctl++;
            if ((c % BYTE_CYC) == BYTE_CYC - 1) begin
                dec_q.push_back(dec);
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL %s byte%0d line got %h want %h", tag, c / BYTE_CYC, obs, expv);
                end
            end
            bus.req = 1'b0;
            for (int i = 0; i < n_inj; i++) if (c == inj[i]) bus.req = 1'b1;
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        checks++;
        if (bad_ctl !== 0) begin
            failures++;
            $display("FAIL %s busy/done during frame got %0d bad cycles want 0", tag, bad_ctl);
        end
    endtask

    // Done cycle after the last stop bit, then the line returns to idle
    task automatic check_fin(input string tag);
        checks++;
        if ({bus.done, bus.busy, bus.tx} !== 3'b101) begin
            failures++;
            $display("FAIL %s fin done,busy,tx got %b want 101", tag, {bus.done, bus.busy, bus.tx});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.busy, bus.tx, bus.rd_addr} !== {3'b001, 8'h00}) begin
            failures++;
            $display("FAIL %s post-fin done,busy,tx,addr got %b %h want 001 00", tag,
                     {bus.done, bus.busy, bus.tx}, bus.rd_addr);
        end
    endtask

    task automatic check_quiet(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s quiet got %0d active cycles want 0", tag, bad);
        end
    endtask

    task automatic check_bytes(input logic [7:0] want [5], input string tag);
        checks++;
        if (dec_q.size() != 5 || dec_q[0] !== want[0] || dec_q[1] !== want[1] || dec_q[2] !== want[2] ||
            dec_q[3] !== want[3] || dec_q[4] !== want[4]) begin
            failures++;
            $display("FAIL %s decoded got %p want %p", tag, dec_q, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.end_flg = 1'b0;
        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL reset tx,busy,done got %b want 100", {bus.tx, bus.busy, bus.done});
        end
        checks++;
        if (bus.rd_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset rd_addr got %h want 00", bus.rd_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [7:0] want [5];
        want = '{8'hA5, 8'h01, 8'h3C, 8'h81, 8'hBC};
        ram[0] = 8'h3C; ram[1] = 8'h81;
        start(1'b1, 1'b0, "single");
        check_frame(8'h01, 1'b0, 0, "single");
        check_bytes(want, "single");
        check_fin("single");
        check_quiet(30, "single");
    endtask

    task automatic test_both();
        logic [7:0] want [5];
        want = '{8'hA5, 8'h03, 8'h3C, 8'h81, 8'hBE};
        start(1'b1, 1'b1, "both");
        check_frame(8'h03, 1'b0, 0, "both");
        check_bytes(want, "both");
        check_fin("both");
        check_quiet(60, "both");
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [5];
        want = '{8'hA5, 8'h02, 8'h3C, 8'h81, 8'hBF};
        start(1'b1, 1'b0, "b2b_first");
        check_frame(8'h01, 1'b0, 3, "b2b_first");
        check_frame(8'h02, 1'b1, 0, "b2b_second");
        check_bytes(want, "b2b_second");
        check_fin("b2b_second");
        check_quiet(60, "b2b_tail");
    endtask

    task automatic test_reset_mid();
        start(1'b1, 1'b0, "rst_mid");
        repeat (2 * BYTE_CYC + 12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid tx,busy,done got %b want 100", {bus.tx, bus.busy, bus.done});
        end
        check_quiet(50, "rst_mid_no_done");
        start(1'b0, 1'b1, "rst_mid_after");
        check_frame(8'h02, 1'b0, 0, "rst_mid_after");
        check_fin("rst_mid_after");
    endtask

    task automatic test_garbage();
        garbage = 1'b1;
        ram[0] = 8'($urandom); ram[1] = 8'($urandom);
        start(1'b1, 1'b0, "garbage");
        check_frame(8'h01, 1'b0, 0, "garbage");
        check_fin("garbage");
        garbage = 1'b0;
    endtask

    task automatic test_random();
        logic e, r;
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < LEN; j++) ram[j] = 8'($urandom);
            e = 1'($urandom);
            r = e ? 1'($urandom) : 1'b1;
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            start(e, r, "random");
            check_frame({6'b0, r, e}, 1'b0, 0, "random");
            check_fin("random");
        end
    endtask

    initial begin
        bus.end_flg = 1'b0;
        bus.req = 1'b0;
        ram[0] = 8'h3C; ram[1] = 8'h81;
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_reset_mid();
        test_garbage();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
